// File: rtl/instr_load_ctrl.sv
// Program-entry sequencer: debounced-by-synchronizer button loads instructions into a packed
// image, then hands it to the hazard checker (req/ack) and enables the core until run_done.
module instr_load_ctrl #(
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = 8,
    parameter logic [DATA_W-1:0] TERM        = 8'hFF,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             input_val,
    input  logic                          but_inp,
    input  logic                          clear,
    input  logic                          chk_ack,
    input  logic                          run_done,
    output logic [DATA_W*DEPTH-1:0]       instrMemBits,
    output logic [$clog2(DEPTH+1)-1:0]    instr_count,
    output logic                          chk_req,
    output logic                          run_en,
    output logic                          loading,
    output logic                          load_err
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_LOAD, S_CHECK, S_RUN, S_DONE} state_t;

    state_t                         state, state_nxt;
    logic [SYNC_STAGES-1:0]         sync_q;
    logic                           sync_prev;
    logic                           press;
    logic                           is_term;
    logic                           wr_en;
    logic                           last_slot;
    logic [DEPTH-1:0][DATA_W-1:0]   mem_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], but_inp};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    // A press coinciding with clear is dropped entirely, including its load_err effect.
    assign press     = sync_q[SYNC_STAGES-1] & ~sync_prev & ~clear;
    assign is_term   = (input_val == TERM);
    assign wr_en     = press && (state == S_LOAD) && !is_term && (instr_count != CNT_W'(DEPTH));
    assign last_slot = (instr_count == CNT_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_LOAD;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (wr_en && last_slot) begin
                        state_nxt = S_CHECK;
                    end else if (press && is_term && (instr_count != '0)) begin
                        state_nxt = S_CHECK;
                    end
                end
                S_CHECK: if (chk_ack)  state_nxt = S_RUN;
                S_RUN:   if (run_done) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_LOAD;
            endcase
        end
    end

    // NOTE: the image is a small register bank that must read as NOPs after reset, so it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '0;
            instr_count <= '0;
            load_err    <= 1'b0;
        end else if (clear) begin
            mem_q       <= '0;
            instr_count <= '0;
            load_err    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[instr_count[IDX_W-1:0]] <= input_val;
                instr_count                   <= instr_count + CNT_W'(1);
            end
            if (press && (state != S_LOAD)) begin
                load_err <= 1'b1;
            end
        end
    end

    // Outputs decode straight from the state register so reset drops them without a clock edge.
    assign instrMemBits = mem_q;
    assign chk_req      = (state == S_CHECK);
    assign run_en       = (state == S_RUN);
    assign loading      = (state == S_LOAD);

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Self-checking bench for instr_load_ctrl: an event-level model compared every cycle,
// plus literal expectations from the directed scenarios.
module tb_instr_load_ctrl;
    localparam logic [1:0] P_LOAD  = 2'd0;
    localparam logic [1:0] P_CHECK = 2'd1;
    localparam logic [1:0] P_RUN   = 2'd2;
    localparam logic [1:0] P_DONE  = 2'd3;

    typedef struct packed {
        logic [7:0][7:0] img;
        logic [3:0]      cnt;
        logic [1:0]      phase;
        logic            err;
        logic [2:0]      hist;   // but_inp as seen at the last three edges, [0] newest
    } model_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  input_val;
    logic        but_inp;
    logic        clear;
    logic        chk_ack;
    logic        run_done;
    logic [63:0] instrMemBits;
    logic [3:0]  instr_count;
    logic        chk_req;
    logic        run_en;
    logic        loading;
    logic        load_err;

    int n_total = 0;
    int n_pass  = 0;
    model_t m;

    instr_load_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_val    (input_val),
        .but_inp      (but_inp),
        .clear        (clear),
        .chk_ack      (chk_ack),
        .run_done     (run_done),
        .instrMemBits (instrMemBits),
        .instr_count  (instr_count),
        .chk_req      (chk_req),
        .run_en       (run_en),
        .loading      (loading),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // A press takes effect at the edge where the button was high two edges earlier and low three edges earlier.
    function automatic model_t step(model_t cur, logic [7:0] v, logic b, logic clr, logic ack, logic done);
        model_t nxt;
        logic   pr;
        nxt      = cur;
        pr       = cur.hist[1] & ~cur.hist[2];
        nxt.hist = {cur.hist[1:0], b};
        if (clr) begin
            nxt.img   = '0;
            nxt.cnt   = '0;
            nxt.phase = P_LOAD;
            nxt.err   = 1'b0;
            return nxt;
        end
        case (cur.phase)
            P_LOAD: if (pr) begin
                if (v != 8'hFF) begin
                    nxt.img[cur.cnt[2:0]] = v;
                    nxt.cnt = cur.cnt + 4'd1;
                    if (nxt.cnt == 4'd8) nxt.phase = P_CHECK;
                end else if (cur.cnt != 4'd0) begin
                    nxt.phase = P_CHECK;
                end
            end
            P_CHECK: if (ack)  nxt.phase = P_RUN;
            P_RUN:   if (done) nxt.phase = P_DONE;
            default: ;
        endcase
        if (pr && cur.phase != P_LOAD) nxt.err = 1'b1;
        return nxt;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, input_val, but_inp, clear, chk_ack, run_done);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_img",     instrMemBits, m.img);
            check("m_count",   64'(instr_count), 64'(m.cnt));
            check("m_chk_req", 64'(chk_req),  64'(m.phase == P_CHECK));
            check("m_run_en",  64'(run_en),   64'(m.phase == P_RUN));
            check("m_loading", 64'(loading),  64'(m.phase == P_LOAD));
            check("m_load_err",64'(load_err), 64'(m.err));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] v);
        input_val = v;
        but_inp   = 1'b1;
        cycles(4);
        but_inp   = 1'b0;
        cycles(4);
    endtask

    logic [7:0] t1 [8] = '{8'h88, 8'h89, 8'h8A, 8'h8C, 8'h90, 8'hA8, 8'h89, 8'h8B};

    initial begin
        clk = 1'b0; rst_n = 1'b0; input_val = '0; but_inp = 1'b0;
        clear = 1'b0; chk_ack = 1'b0; run_done = 1'b0;
        cycles(2);
        check("rst_loading", 64'(loading), 64'd1);
        check("rst_count",   64'(instr_count), 64'd0);
        check("rst_img",     instrMemBits, 64'd0);
        check("rst_chk_req", 64'(chk_req), 64'd0);
        check("rst_run_en",  64'(run_en), 64'd0);
        check("rst_load_err",64'(load_err), 64'd0);
        rst_n = 1'b1;
        cycles(2);

        // Terminator on an empty program is ignored; stray ack in load too.
        press(8'hFF);
        check("term_empty_loading", 64'(loading), 64'd1);
        chk_ack = 1'b1; cycles(1); chk_ack = 1'b0; cycles(1);
        check("ack_in_load", 64'(loading), 64'd1);

        // Press landing on the same edge as clear is dropped.
        input_val = 8'h55; but_inp = 1'b1;
        cycles(2); clear = 1'b1; cycles(1); clear = 1'b0;
        cycles(2); but_inp = 1'b0; cycles(4);
        check("press_with_clear", 64'(instr_count), 64'd0);

        // Eight writes fill the image and enter check on the 8th write edge.
        for (int i = 0; i < 7; i++) press(t1[i]);
        input_val = t1[7]; but_inp = 1'b1;
        cycles(2);
        check("t1_count7",  64'(instr_count), 64'd7);
        check("t1_req_low", 64'(chk_req), 64'd0);
        cycles(1);
        check("t1_count8",  64'(instr_count), 64'd8);
        check("t1_req_hi",  64'(chk_req), 64'd1);
        check("t1_img",     instrMemBits, 64'h8B89A8908C8A8988);
        cycles(1); but_inp = 1'b0; cycles(4);
        chk_ack = 1'b1; cycles(1); chk_ack = 1'b0;
        check("t1_run_en", 64'(run_en), 64'd1);
        run_done = 1'b1; cycles(1); run_done = 1'b0;
        check("t1_done_run_en", 64'(run_en), 64'd0);
        clear = 1'b1; cycles(1); clear = 1'b0;

        // Early terminator, then ack+clear together: clear wins.
        press(8'h88); press(8'h89); press(8'hFF);
        check("t2_count",   64'(instr_count), 64'd2);
        check("t2_img",     instrMemBits, 64'h0000_0000_0000_8988);
        check("t2_chk_req", 64'(chk_req), 64'd1);
        chk_ack = 1'b1; clear = 1'b1; cycles(1); chk_ack = 1'b0; clear = 1'b0;
        check("ack_clear_loading", 64'(loading), 64'd1);
        check("ack_clear_count",   64'(instr_count), 64'd0);

        // Delayed ack: request and image hold steady.
        press(8'h88); press(8'h89); press(8'hFF);
        cycles(10);
        check("t4_req_held", 64'(chk_req), 64'd1);
        check("t4_img_held", instrMemBits, 64'h0000_0000_0000_8988);
        chk_ack = 1'b1; cycles(1); chk_ack = 1'b0;
        check("t4_run_en",  64'(run_en), 64'd1);
        check("t4_req_off", 64'(chk_req), 64'd0);

        // Press while running flags an error and leaves the image alone.
        press(8'h3C);
        check("t5_load_err", 64'(load_err), 64'd1);
        check("t5_img",      instrMemBits, 64'h0000_0000_0000_8988);
        check("t5_run_en",   64'(run_en), 64'd1);
        cycles(3); run_done = 1'b1; cycles(1); run_done = 1'b0;
        cycles(3);
        check("t5_done_run_en",  64'(run_en), 64'd0);
        check("t5_done_loading", 64'(loading), 64'd0);
        check("t5_done_img",     instrMemBits, 64'h0000_0000_0000_8988);
        clear = 1'b1; cycles(1); clear = 1'b0;
        check("t5_clr_count",   64'(instr_count), 64'd0);
        check("t5_clr_img",     instrMemBits, 64'd0);
        check("t5_clr_err",     64'(load_err), 64'd0);
        check("t5_clr_loading", 64'(loading), 64'd1);

        // Held button yields exactly one write, landing on the third edge after the rise.
        input_val = 8'h91; but_inp = 1'b1;
        cycles(2);
        check("t3_before", 64'(instr_count), 64'd0);
        cycles(1);
        check("t3_first",  64'(instr_count), 64'd1);
        check("t3_img",    instrMemBits, 64'h0000_0000_0000_0091);
        cycles(47);
        check("t3_held",   64'(instr_count), 64'd1);
        but_inp = 1'b0; cycles(4);

        // Asynchronous reset mid-handshake.
        press(8'hFF);
        check("t6_req_before", 64'(chk_req), 64'd1);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        check("t6_req",     64'(chk_req), 64'd0);
        check("t6_run_en",  64'(run_en), 64'd0);
        check("t6_loading", 64'(loading), 64'd1);
        check("t6_count",   64'(instr_count), 64'd0);
        check("t6_img",     instrMemBits, 64'd0);
        check("t6_err",     64'(load_err), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
